// File: rtl/framebuffer_fill_if.sv
// Command and framebuffer-write bundle for the rectangle-fill blitter.
// master = command source / framebuffer side, slave = the blitter itself.
interface framebuffer_fill_if #(
  parameter int ADDR_W = 17
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [8:0]        cmd_x;
  logic [7:0]        cmd_y;
  logic [8:0]        cmd_w;
  logic [7:0]        cmd_h;
  logic [7:0]        cmd_color;

  logic              wr_enable;
  logic [ADDR_W-1:0] wr_address;
  logic [7:0]        wr_data;
  logic              wr_stall;

  modport master (
    output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, wr_stall,
    input  cmd_ready, wr_enable, wr_address, wr_data
  );

  modport slave (
    input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, wr_stall,
    output cmd_ready, wr_enable, wr_address, wr_data
  );
endinterface

// File: rtl/framebuffer_fill.sv
// Rectangle-fill blitter: clips one command to the screen and emits one
// framebuffer write per pixel in raster order, honouring write back-pressure.
module framebuffer_fill #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  framebuffer_fill_if.slave bus,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] pixel_count
);

  typedef enum logic [1:0] {ST_IDLE, ST_CLIP, ST_FILL, ST_DONE} state_t;

  localparam logic [9:0]        WIDTH_X  = 10'(WIDTH);
  localparam logic [8:0]        HEIGHT_Y = 9'(HEIGHT);
  localparam logic [ADDR_W-1:0] WIDTH_A  = ADDR_W'(WIDTH);

  state_t            state;
  logic [8:0]        x_q, w_q, col_q;
  logic [7:0]        y_q, h_q, row_q, color_q;
  logic [9:0]        x_end_q;
  logic [8:0]        y_end_q;
  logic [ADDR_W-1:0] row_base_q;
  logic              wr_enable_q;
  logic [ADDR_W-1:0] wr_address_q;
  logic [7:0]        wr_data_q;
  logic              done_q;
  logic [ADDR_W-1:0] pixel_count_q;

  logic [9:0]        x_sum, x_end_c;
  logic [8:0]        y_sum, y_end_c;
  logic              empty;
  logic [ADDR_W-1:0] row_base_c;
  logic              last_col, last_row;

  // Sums are widened by one bit so a rectangle hanging off the edge cannot wrap.
  // NOTE: every always_comb output gets a default first, so no latch is inferred.
  always_comb begin
    x_sum      = {1'b0, x_q} + {1'b0, w_q};
    y_sum      = {1'b0, y_q} + {1'b0, h_q};
    x_end_c    = (x_sum > WIDTH_X)  ? WIDTH_X  : x_sum;
    y_end_c    = (y_sum > HEIGHT_Y) ? HEIGHT_Y : y_sum;
    empty      = (w_q == '0) || (h_q == '0) ||
                 ({1'b0, x_q} >= WIDTH_X) || ({1'b0, y_q} >= HEIGHT_Y);
    row_base_c = ADDR_W'(y_q) * WIDTH_A;
    last_col   = (({1'b0, col_q} + 10'd1) == x_end_q);
    last_row   = (({1'b0, row_q} + 9'd1) == y_end_q);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side below sees the pre-edge value regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      x_q           <= '0;
      y_q           <= '0;
      w_q           <= '0;
      h_q           <= '0;
      color_q       <= '0;
      col_q         <= '0;
      row_q         <= '0;
      x_end_q       <= '0;
      y_end_q       <= '0;
      row_base_q    <= '0;
      wr_enable_q   <= 1'b0;
      wr_address_q  <= '0;
      wr_data_q     <= '0;
      done_q        <= 1'b0;
      pixel_count_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            x_q           <= bus.cmd_x;
            y_q           <= bus.cmd_y;
            w_q           <= bus.cmd_w;
            h_q           <= bus.cmd_h;
            color_q       <= bus.cmd_color;
            pixel_count_q <= '0;
            state         <= ST_CLIP;
          end
        end

        ST_CLIP: begin
          x_end_q <= x_end_c;
          y_end_q <= y_end_c;
          if (empty) begin
            done_q <= 1'b1;
            state  <= ST_DONE;
          end else begin
            col_q        <= x_q;
            row_q        <= y_q;
            row_base_q   <= row_base_c;
            wr_address_q <= row_base_c + ADDR_W'(x_q);
            wr_data_q    <= color_q;
            wr_enable_q  <= 1'b1;
            state        <= ST_FILL;
          end
        end

        // The address is kept as a running register so the write port never
        // sees a path from wr_stall; it only moves after a completed write.
        ST_FILL: begin
          if (!bus.wr_stall) begin
            pixel_count_q <= pixel_count_q + ADDR_W'(1);
            if (last_col) begin
              if (last_row) begin
                wr_enable_q <= 1'b0;
                done_q      <= 1'b1;
                state       <= ST_DONE;
              end else begin
                col_q        <= x_q;
                row_q        <= row_q + 8'd1;
                row_base_q   <= row_base_q + WIDTH_A;
                wr_address_q <= row_base_q + WIDTH_A + ADDR_W'(x_q);
              end
            end else begin
              col_q        <= col_q + 9'd1;
              wr_address_q <= wr_address_q + ADDR_W'(1);
            end
          end
        end

        ST_DONE: state <= ST_IDLE;

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready  = (state == ST_IDLE);
  assign bus.wr_enable  = wr_enable_q;
  assign bus.wr_address = wr_address_q;
  assign bus.wr_data    = wr_data_q;
  assign busy           = (state != ST_IDLE);
  assign done           = done_q;
  assign pixel_count    = pixel_count_q;

endmodule

// File: tb/tb_framebuffer_fill.sv
// Self-checking bench for framebuffer_fill: directed table, stall/reset
// sequences and randomized commands against a raster-order pixel model.
module tb_framebuffer_fill;
  localparam int WIDTH  = 320;
  localparam int HEIGHT = 240;
  localparam int ADDR_W = 17;

  typedef struct {
    logic [8:0] x;
    logic [7:0] y;
    logic [8:0] w;
    logic [7:0] h;
    logic [7:0] color;
  } cmd_t;

  typedef struct {
    cmd_t  cmd;
    int    n;
    int    first;
    int    last;
    string name;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              busy, done;
  logic [ADDR_W-1:0] pixel_count;

  framebuffer_fill_if #(.ADDR_W(ADDR_W)) bus ();

  framebuffer_fill #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .busy        (busy),
    .done        (done),
    .pixel_count (pixel_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];
  int got_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Reference: every on-screen pixel of the rectangle, row by row.
  function automatic void build_model(input cmd_t c);
    int x_end, y_end;
    exp_q.delete();
    x_end = int'(c.x) + int'(c.w);
    y_end = int'(c.y) + int'(c.h);
    if (x_end > WIDTH)  x_end = WIDTH;
    if (y_end > HEIGHT) y_end = HEIGHT;
    for (int r = int'(c.y); r < y_end; r++)
      for (int col = int'(c.x); col < x_end; col++)
        exp_q.push_back(r * WIDTH + col);
  endfunction

  // stall_mode: 0 none, 1 alternate cycles, 2 random. poke drives junk commands while busy.
  task automatic run_cmd(input cmd_t c, input int stall_mode, input bit poke, input string tag);
    int n_exp, budget, n_we, first_we, last_cmp, done_cyc, pc_at_done;
    logic held;
    logic [ADDR_W-1:0] held_addr;
    logic [7:0] held_data;
    build_model(c);
    got_q.delete();
    n_exp = exp_q.size();
    budget = 4 * n_exp + 20;
    n_we = 0; first_we = -1; last_cmp = -1; done_cyc = -1; pc_at_done = -1;
    held = 1'b0; held_addr = '0; held_data = '0;

    @(negedge clk);
    for (int i = 0; i < 50 && !bus.cmd_ready; i++) @(negedge clk);
    check({tag, " ready before accept"}, bus.cmd_ready, 1);
    bus.cmd_x = c.x; bus.cmd_y = c.y; bus.cmd_w = c.w; bus.cmd_h = c.h;
    bus.cmd_color = c.color; bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;

    for (int cyc = 1; cyc <= budget; cyc++) begin
      case (stall_mode)
        0:       bus.wr_stall = 1'b0;
        1:       bus.wr_stall = (cyc % 2 == 0);
        default: bus.wr_stall = ($urandom_range(0, 2) == 0);
      endcase
      if (poke) begin
        bus.cmd_valid = 1'($urandom_range(0, 1));
        bus.cmd_x = 9'($urandom); bus.cmd_y = 8'($urandom);
        bus.cmd_w = 9'($urandom); bus.cmd_h = 8'($urandom);
        bus.cmd_color = 8'($urandom);
      end
      @(negedge clk);
      if (cyc == 1) begin
        check({tag, " clip busy"}, busy, 1);
        check({tag, " clip no write"}, bus.wr_enable, 0);
      end
      if (held) begin
        check({tag, " stall hold enable"}, bus.wr_enable, 1);
        check({tag, " stall hold address"}, bus.wr_address, held_addr);
        check({tag, " stall hold data"}, bus.wr_data, held_data);
      end
      held = 1'b0;
      if (bus.wr_enable) begin
        n_we++;
        if (first_we < 0) first_we = cyc;
        if (bus.wr_stall) begin
          held = 1'b1; held_addr = bus.wr_address; held_data = bus.wr_data;
        end else begin
          got_q.push_back(int'(bus.wr_address));
          last_cmp = cyc;
          check({tag, " write data"}, bus.wr_data, c.color);
        end
      end
      if (done) begin
        done_cyc = cyc;
        pc_at_done = int'(pixel_count);
        check({tag, " done without write"}, bus.wr_enable, 0);
        break;
      end
      @(posedge clk); #1;
    end
    bus.cmd_valid = 1'b0;
    bus.wr_stall  = 1'b0;

    check({tag, " done seen"}, done_cyc >= 0, 1);
    check({tag, " write count"}, got_q.size(), n_exp);
    for (int i = 0; i < got_q.size() && i < n_exp; i++)
      check({tag, " address"}, got_q[i], exp_q[i]);
    if (stall_mode == 0) begin
      check({tag, " enable cycles"}, n_we, n_exp);
      if (n_exp > 0) check({tag, " first write cycle"}, first_we, 2);
      check({tag, " done cycle"}, done_cyc, 2 + n_exp);
    end else begin
      check({tag, " done cycle"}, done_cyc, (n_exp > 0) ? last_cmp + 1 : 2);
    end
    check({tag, " pixel count at done"}, pc_at_done, n_exp);

    @(negedge clk);
    check({tag, " ready after done"}, bus.cmd_ready, 1);
    check({tag, " idle after done"}, busy, 0);
    check({tag, " done is a pulse"}, done, 0);
    check({tag, " pixel count held"}, pixel_count, n_exp);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " ready"}, bus.cmd_ready, 1);
    check({tag, " wr_enable"}, bus.wr_enable, 0);
    check({tag, " wr_address"}, bus.wr_address, 0);
    check({tag, " wr_data"}, bus.wr_data, 0);
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, done, 0);
    check({tag, " pixel_count"}, pixel_count, 0);
  endtask

  vec_t vecs[$];

  initial begin
    cmd_t c;
    int   completions;

    bus.cmd_valid = 1'b0; bus.cmd_x = '0; bus.cmd_y = '0; bus.cmd_w = '0;
    bus.cmd_h = '0; bus.cmd_color = '0; bus.wr_stall = 1'b0;

    vecs.push_back('{'{9'd10,  8'd2,   9'd3,   8'd2,   8'hE0}, 6,  650,   972,   "basic 3x2"});
    vecs.push_back('{'{9'd318, 8'd239, 9'd5,   8'd4,   8'h1C}, 2,  76798, 76799, "clip corner"});
    vecs.push_back('{'{9'd5,   8'd5,   9'd0,   8'd3,   8'h03}, 0,  -1,    -1,    "empty w0"});
    vecs.push_back('{'{9'd320, 8'd0,   9'd4,   8'd4,   8'h55}, 0,  -1,    -1,    "empty x320"});
    vecs.push_back('{'{9'd0,   8'd240, 9'd4,   8'd4,   8'hAA}, 0,  -1,    -1,    "empty y240"});
    vecs.push_back('{'{9'd7,   8'd9,   9'd2,   8'd0,   8'h11}, 0,  -1,    -1,    "empty h0"});
    vecs.push_back('{'{9'd300, 8'd0,   9'd511, 8'd1,   8'hFF}, 20, 300,   319,   "wide clip"});
    vecs.push_back('{'{9'd0,   8'd230, 9'd1,   8'd255, 8'h42}, 10, 73600, 76480, "tall clip"});
    vecs.push_back('{'{9'd0,   8'd0,   9'd1,   8'd1,   8'h99}, 1,  0,     0,     "origin 1x1"});

    // Reset, then an asynchronous reset pulse while idle.
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_state("reset idle");
    @(negedge clk); rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_cmd(vecs[i].cmd, 0, 1'b0, vecs[i].name);
      check({vecs[i].name, " table count"}, got_q.size(), vecs[i].n);
      if (vecs[i].n > 0 && got_q.size() > 0) begin
        check({vecs[i].name, " table first"}, got_q[0], vecs[i].first);
        check({vecs[i].name, " table last"}, got_q[got_q.size()-1], vecs[i].last);
      end
    end

    // Alternate-cycle stall on the basic command, with junk commands poked while busy.
    c = '{9'd10, 8'd2, 9'd3, 8'd2, 8'hE0};
    run_cmd(c, 1, 1'b1, "alt stall");

    // Asynchronous reset after the third completed write of the basic command.
    @(negedge clk);
    bus.cmd_x = 9'd10; bus.cmd_y = 8'd2; bus.cmd_w = 9'd3; bus.cmd_h = 8'd2;
    bus.cmd_color = 8'hE0; bus.cmd_valid = 1'b1;
    @(posedge clk); #1 bus.cmd_valid = 1'b0;
    completions = 0;
    for (int i = 0; i < 20 && completions < 3; i++) begin
      @(negedge clk);
      if (bus.wr_enable && !bus.wr_stall) completions++;
    end
    check("reset mid-fill reached 3 writes", completions, 3);
    #2 rst_n = 1'b0;
    #1;
    check("reset mid-fill wr_enable", bus.wr_enable, 0);
    check("reset mid-fill busy", busy, 0);
    check("reset mid-fill pixel_count", pixel_count, 0);
    repeat (2) begin
      @(negedge clk);
      check("reset held no write", bus.wr_enable, 0);
    end
    rst_n = 1'b1;
    c = '{9'd0, 8'd0, 9'd1, 8'd1, 8'h3C};
    run_cmd(c, 0, 1'b0, "after reset 1x1");

    // Randomized commands with random stalls and junk commands while busy.
    for (int i = 0; i < 40; i++) begin
      c.x     = 9'($urandom_range(0, 340));
      c.y     = 8'($urandom_range(0, 255));
      c.w     = 9'($urandom_range(0, 24));
      c.h     = 8'($urandom_range(0, 12));
      c.color = 8'($urandom);
      run_cmd(c, $urandom_range(0, 2), 1'($urandom_range(0, 1)), "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
